// File: rtl/ro_puf_if.sv
// ---------------------------------------------------------------------------
// ro_puf_if
//   Bundles every non-clock signal of the RO PUF sequencer.
//   The bundle covers the host challenge/response handshake and the RO bank/counter
//   control and result lines.
//   master : host + RO bank/counter side (drives req, challenge, resp_ready,
//            cnt_done, count1, count2)
//   slave  : the sequencer (drives ro_en, ro_sel, cnt_start, busy, response,
//            resp_valid, tie_cnt, timeout_err)
// Parameters must match those of the attached ro_puf_sequencer.
// ---------------------------------------------------------------------------
interface ro_puf_if #(
    parameter int SEL_W     = 4,
    parameter int RESP_BITS = 16
) ();
    // host request side
    logic                 req;
    logic [SEL_W-1:0]     challenge;
    logic                 resp_ready;
    // RO bank / race counter side
    logic                 ro_en;
    logic [SEL_W-1:0]     ro_sel;
    logic                 cnt_start;
    logic                 cnt_done;
    logic [7:0]           count1;
    logic [7:0]           count2;
    // status / response side
    logic                 busy;
    logic [RESP_BITS-1:0] response;
    logic                 resp_valid;
    logic [6:0]           tie_cnt;
    logic                 timeout_err;

    modport master (
        output req, challenge, resp_ready, cnt_done, count1, count2,
        input  ro_en, ro_sel, cnt_start, busy, response, resp_valid,
               tie_cnt, timeout_err
    );

    modport slave (
        input  req, challenge, resp_ready, cnt_done, count1, count2,
        output ro_en, ro_sel, cnt_start, busy, response, resp_valid,
               tie_cnt, timeout_err
    );
endinterface

// File: rtl/ro_puf_sequencer.sv
// ---------------------------------------------------------------------------
// ro_puf_sequencer
//   Drives the ring-oscillator race counter to build a RESP_BITS-wide PUF
//   response. For every response bit: select an RO pair, let it settle with
//   the counter held clear, run one race, compare the two counts.
//
// Ports
//   clk     system clock
//   rst_n   asynchronous active-low reset; aborts any request in flight
//   bus     ro_puf_if.slave
//             req/challenge      start request + first pair index (IDLE only)
//             resp_ready         host accepts response in DONE
//             ro_en/ro_sel       RO bank enable and pair select
//             cnt_start          counter run (low holds the counter cleared)
//             cnt_done           race finished (looked at only in MEASURE)
//             count1/count2      race counts of RO A / RO B
//             busy               high in every state except IDLE
//             response           bit i = result of race i
//             resp_valid         response word valid (DONE)
//             tie_cnt            races with count1 == count2, saturating
//             timeout_err        sticky: some race ran out of time
//
// The challenge is expected to be below NUM_PAIRS; the pointer wraps from
// NUM_PAIRS-1 back to 0.
// ---------------------------------------------------------------------------
module ro_puf_sequencer #(
    parameter int NUM_PAIRS      = 16,
    parameter int SEL_W          = 4,
    parameter int RESP_BITS      = 16,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic     clk,
    input  logic     rst_n,
    ro_puf_if.slave  bus
);
    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(RESP_BITS - 1);
    localparam logic [SEL_W-1:0] LAST_PAIR    = SEL_W'(NUM_PAIRS - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TIMEOUT_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        MEASURE,
        COMPARE,
        RELEASE,
        DONE
    } state_t;

    state_t               state_reg;
    logic [SEL_W-1:0]     ptr_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [SET_W-1:0]     settle_reg;
    logic [TO_W-1:0]      tmo_reg;
    logic                 race_to_reg;    // current race ended by timeout
    logic                 ro_en_reg;
    logic [SEL_W-1:0]     ro_sel_reg;
    logic                 cnt_start_reg;
    logic                 busy_reg;
    logic [RESP_BITS-1:0] response_reg;
    logic                 resp_valid_reg;
    logic [6:0]           tie_cnt_reg;
    logic                 timeout_err_reg;

    logic [SEL_W-1:0]     ptr_next;
    logic [RESP_BITS-1:0] bit_mask;
    logic                 race_bit;
    logic                 race_tie;

    // One-hot mask of the response bit owned by the current race.
    for (genvar gi = 0; gi < RESP_BITS; gi++) begin : g_bit_mask
        assign bit_mask[gi] = (idx_reg == IDX_W'(gi));
    end

    // Next pair wraps at NUM_PAIRS-1, not at the select width.
    always_comb begin
        ptr_next = ptr_reg + SEL_W'(1);
        if (ptr_reg == LAST_PAIR) begin
            ptr_next = '0;
        end
    end

    // A timed-out race has no trustworthy counts: its bit is forced to 0
    // and it is not reported as a tie.
    always_comb begin
        race_bit = 1'b0;
        race_tie = 1'b0;
        if (!race_to_reg) begin
            race_bit = (bus.count1 > bus.count2);
            race_tie = (bus.count1 == bus.count2);
        end
    end

    // Outputs are registered: each output takes its new value on the same
    // edge that enters the state in which that value applies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            idx_reg         <= '0;
            settle_reg      <= '0;
            tmo_reg         <= '0;
            race_to_reg     <= 1'b0;
            ro_en_reg       <= 1'b0;
            ro_sel_reg      <= '0;
            cnt_start_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            response_reg    <= '0;
            resp_valid_reg  <= 1'b0;
            tie_cnt_reg     <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req) begin
                        ptr_reg         <= bus.challenge;
                        ro_sel_reg      <= bus.challenge;
                        idx_reg         <= '0;
                        tie_cnt_reg     <= '0;
                        timeout_err_reg <= 1'b0;
                        response_reg    <= '0;
                        settle_reg      <= SETTLE_LOAD;
                        ro_en_reg       <= 1'b1;
                        busy_reg        <= 1'b1;
                        state_reg       <= SELECT;
                    end
                end

                SELECT: begin
                    // Oscillators run with the counter held clear.
                    if (settle_reg == '0) begin
                        cnt_start_reg <= 1'b1;
                        tmo_reg       <= TIMEOUT_LOAD;
                        race_to_reg   <= 1'b0;
                        state_reg     <= MEASURE;
                    end else begin
                        settle_reg <= settle_reg - SET_W'(1);
                    end
                end

                MEASURE: begin
                    // A done arriving on the last allowed cycle still counts
                    // as a normal finish.
                    if (bus.cnt_done) begin
                        state_reg <= COMPARE;
                    end else if (tmo_reg == '0) begin
                        race_to_reg     <= 1'b1;
                        timeout_err_reg <= 1'b1;
                        state_reg       <= COMPARE;
                    end else begin
                        tmo_reg <= tmo_reg - TO_W'(1);
                    end
                end

                COMPARE: begin
                    // cnt_start is still high here, so the counts are frozen.
                    response_reg <= (response_reg & ~bit_mask)
                                  | (race_bit ? bit_mask : '0);
                    if (race_tie && (tie_cnt_reg != 7'd127)) begin
                        tie_cnt_reg <= tie_cnt_reg + 7'd1;
                    end
                    cnt_start_reg <= 1'b0;
                    ro_en_reg     <= 1'b0;
                    state_reg     <= RELEASE;
                end

                RELEASE: begin
                    ptr_reg <= ptr_next;
                    idx_reg <= idx_reg + IDX_W'(1);
                    if (idx_reg == LAST_IDX) begin
                        resp_valid_reg <= 1'b1;
                        state_reg      <= DONE;
                    end else begin
                        ro_sel_reg <= ptr_next;
                        ro_en_reg  <= 1'b1;
                        settle_reg <= SETTLE_LOAD;
                        state_reg  <= SELECT;
                    end
                end

                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.ro_en       = ro_en_reg;
    assign bus.ro_sel      = ro_sel_reg;
    assign bus.cnt_start   = cnt_start_reg;
    assign bus.busy        = busy_reg;
    assign bus.response    = response_reg;
    assign bus.resp_valid  = resp_valid_reg;
    assign bus.tie_cnt     = tie_cnt_reg;
    assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ro_puf_sequencer
//   dut_a: 16 pairs, 16 bits, settle 8, timeout 4096.
//   dut_b: 10 pairs, 12 bits, settle 3, timeout 16 (pair wrap 9 -> 0).
//   Each DUT has a behavioural RO counter model. The model for dut_a is
//   driven by per-race tables: count1, count2, done delay and hang. The
//   model logs ro_sel and the number of cnt_start-high cycles for each race.
//   Expected response words go into a scoreboard queue when a request is
//   issued. They are popped and compared once resp_valid is seen.
// ---------------------------------------------------------------------------
module tb_ro_puf_sequencer;
    localparam int A_PAIRS  = 16;
    localparam int A_BITS   = 16;
    localparam int A_SETTLE = 8;
    localparam int A_TMO    = 4096;
    localparam int B_PAIRS  = 10;
    localparam int B_BITS   = 12;
    localparam int B_SETTLE = 3;
    localparam int B_TMO    = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ro_puf_if #(.SEL_W(4), .RESP_BITS(A_BITS)) bus_a ();
    ro_puf_if #(.SEL_W(4), .RESP_BITS(B_BITS)) bus_b ();

    ro_puf_sequencer #(
        .NUM_PAIRS(A_PAIRS), .SEL_W(4), .RESP_BITS(A_BITS),
        .SETTLE_CYCLES(A_SETTLE), .TIMEOUT_CYCLES(A_TMO)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    ro_puf_sequencer #(
        .NUM_PAIRS(B_PAIRS), .SEL_W(4), .RESP_BITS(B_BITS),
        .SETTLE_CYCLES(B_SETTLE), .TIMEOUT_CYCLES(B_TMO)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    typedef struct {
        logic [15:0] resp;
        logic [6:0]  tie;
        logic        to;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // per-race stimulus for dut_a's counter model
    int   c1_tab[64];
    int   c2_tab[64];
    int   dly_tab[64];
    bit   hang_tab[64];

    logic [3:0] sel_log_a[512];
    int         meas_log_a[512];
    logic [3:0] sel_log_b[512];
    int race_a = 0, base_a = 0, cur_a = 0, mcyc_a = 0;
    bit prev_a = 1'b0;
    int race_b = 0, base_b = 0;
    bit prev_b = 1'b0;

    // RO counter model for dut_a
    always @(negedge clk) begin
        if (bus_a.cnt_start === 1'b1) begin
            if (!prev_a) begin
                cur_a = race_a - base_a;
                sel_log_a[race_a % 512] = bus_a.ro_sel;
                race_a++;
                mcyc_a = 0;
            end
            mcyc_a++;
            bus_a.count1 = 8'(c1_tab[cur_a % 64]);
            bus_a.count2 = 8'(c2_tab[cur_a % 64]);
            bus_a.cnt_done = (!hang_tab[cur_a % 64] && mcyc_a >= dly_tab[cur_a % 64]);
            prev_a = 1'b1;
        end else begin
            if (prev_a) meas_log_a[(race_a - 1) % 512] = mcyc_a;
            bus_a.cnt_done = 1'b0;
            bus_a.count1 = 8'd0;
            bus_a.count2 = 8'd0;
            prev_a = 1'b0;
        end
    end

    // RO counter model for dut_b: done at once, RO A always faster
    always @(negedge clk) begin
        if (bus_b.cnt_start === 1'b1) begin
            if (!prev_b) begin
                sel_log_b[race_b % 512] = bus_b.ro_sel;
                race_b++;
            end
            bus_b.cnt_done = 1'b1;
            bus_b.count1 = 8'd2;
            bus_b.count2 = 8'd1;
            prev_b = 1'b1;
        end else begin
            bus_b.cnt_done = 1'b0;
            bus_b.count1 = 8'd0;
            bus_b.count2 = 8'd0;
            prev_b = 1'b0;
        end
    end

    task automatic set_tables(input int c1, input int c2, input int dly);
        for (int i = 0; i < 64; i++) begin
            c1_tab[i] = c1; c2_tab[i] = c2; dly_tab[i] = dly; hang_tab[i] = 1'b0;
        end
    endtask

    // Issue one request on dut_a; returns cycles from req to resp_valid.
    task automatic run_a(input logic [3:0] chal, input int limit, output int lat, output bit ok);
        @(negedge clk);
        bus_a.challenge = chal;
        bus_a.req = 1'b1;
        base_a = race_a;
        lat = 0;
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk); #1;
            lat++;
            bus_a.req = 1'b0;
            if (bus_a.resp_valid === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_b(input logic [3:0] chal, input int limit, output int lat, output bit ok);
        @(negedge clk);
        bus_b.challenge = chal;
        bus_b.req = 1'b1;
        base_b = race_b;
        lat = 0;
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk); #1;
            lat++;
            bus_b.req = 1'b0;
            if (bus_b.resp_valid === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic ack_a();
        @(negedge clk); bus_a.resp_ready = 1'b1;
        @(posedge clk); #1; bus_a.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus_a.ro_en !== 1'b0) begin n_fail++; $display("FAIL reset_ro_en: got %b want 0", bus_a.ro_en); end
        n_checks++; if (bus_a.ro_sel !== 4'd0) begin n_fail++; $display("FAIL reset_ro_sel: got %0d want 0", bus_a.ro_sel); end
        n_checks++; if (bus_a.cnt_start !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_start: got %b want 0", bus_a.cnt_start); end
        n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
        n_checks++; if (bus_a.response !== 16'h0) begin n_fail++; $display("FAIL reset_response: got %h want 0000", bus_a.response); end
        n_checks++; if (bus_a.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", bus_a.resp_valid); end
        n_checks++; if (bus_a.tie_cnt !== 7'd0) begin n_fail++; $display("FAIL reset_tie_cnt: got %0d want 0", bus_a.tie_cnt); end
        n_checks++; if (bus_a.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", bus_a.timeout_err); end
        n_checks++; if ({bus_b.busy, bus_b.resp_valid, bus_b.response} !== 14'd0) begin n_fail++; $display("FAIL reset_dut_b: got %h want 0", {bus_b.busy, bus_b.resp_valid, bus_b.response}); end
        @(negedge clk); rst_n = 1'b1;
        $display("txn reset: released");
    endtask

    // count1 > count2 on every race, challenge 0
    task automatic test_all_ones();
        exp_t e; int lat; bit ok;
        set_tables(200, 100, 3);
        e.resp = 16'hFFFF; e.tie = 7'd0; e.to = 1'b0; e.lat = A_BITS * (A_SETTLE + 3 + 2) + 1;
        sb_q.push_back(e);
        run_a(4'd0, 6000, lat, ok);
        e = sb_q.pop_front();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL all_ones_valid: resp_valid not seen within bound"); end
        n_checks++; if (bus_a.response !== e.resp) begin n_fail++; $display("FAIL all_ones_response: got %h want %h", bus_a.response, e.resp); end
        n_checks++; if (bus_a.tie_cnt !== e.tie) begin n_fail++; $display("FAIL all_ones_tie: got %0d want %0d", bus_a.tie_cnt, e.tie); end
        n_checks++; if (bus_a.timeout_err !== e.to) begin n_fail++; $display("FAIL all_ones_timeout: got %b want %b", bus_a.timeout_err, e.to); end
        n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL all_ones_latency: got %0d want %0d", lat, e.lat); end
        n_checks++; if ({bus_a.busy, bus_a.ro_en, bus_a.cnt_start} !== 3'b100) begin n_fail++; $display("FAIL all_ones_done_ctrl: got %b want 100", {bus_a.busy, bus_a.ro_en, bus_a.cnt_start}); end
        for (int k = 0; k < A_BITS; k++) begin
            n_checks++;
            if (sel_log_a[(base_a + k) % 512] !== 4'(k)) begin
                n_fail++; $display("FAIL all_ones_sel[%0d]: got %0d want %0d", k, sel_log_a[(base_a + k) % 512], k);
            end
        end
        $display("txn all_ones: chal=0 resp=%h tie=%0d to=%b lat=%0d", bus_a.response, bus_a.tie_cnt, bus_a.timeout_err, lat);
        ack_a();
        n_checks++; if ({bus_a.resp_valid, bus_a.busy} !== 2'b00) begin n_fail++; $display("FAIL all_ones_ack: got %b want 00", {bus_a.resp_valid, bus_a.busy}); end
    endtask

    // Pair pointer wrap at NUM_PAIRS-1 (16 pairs and 10 pairs)
    task automatic test_wrap();
        exp_t e; int lat; bit ok;
        set_tables(9, 4, 1);
        e.resp = 16'hFFFF; e.tie = 7'd0; e.to = 1'b0; e.lat = A_BITS * (A_SETTLE + 1 + 2) + 1;
        sb_q.push_back(e);
        run_a(4'd14, 6000, lat, ok);
        e = sb_q.pop_front();
        n_checks++; if (!ok || bus_a.response !== e.resp) begin n_fail++; $display("FAIL wrap16_response: got %h want %h (valid seen %b)", bus_a.response, e.resp, ok); end
        n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL wrap16_latency: got %0d want %0d", lat, e.lat); end
        for (int k = 0; k < A_BITS; k++) begin
            n_checks++;
            if (sel_log_a[(base_a + k) % 512] !== 4'((14 + k) % A_PAIRS)) begin
                n_fail++; $display("FAIL wrap16_sel[%0d]: got %0d want %0d", k, sel_log_a[(base_a + k) % 512], (14 + k) % A_PAIRS);
            end
        end
        $display("txn wrap16: chal=14 resp=%h lat=%0d", bus_a.response, lat);
        ack_a();

        e.resp = 16'h0FFF; e.tie = 7'd0; e.to = 1'b0; e.lat = B_BITS * (B_SETTLE + 1 + 2) + 1;
        sb_q.push_back(e);
        run_b(4'd7, 1000, lat, ok);
        e = sb_q.pop_front();
        n_checks++; if (!ok || bus_b.response !== e.resp[B_BITS-1:0]) begin n_fail++; $display("FAIL wrap10_response: got %h want %h (valid seen %b)", bus_b.response, e.resp[B_BITS-1:0], ok); end
        n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL wrap10_latency: got %0d want %0d", lat, e.lat); end
        for (int k = 0; k < B_BITS; k++) begin
            n_checks++;
            if (sel_log_b[(base_b + k) % 512] !== 4'((7 + k) % B_PAIRS)) begin
                n_fail++; $display("FAIL wrap10_sel[%0d]: got %0d want %0d", k, sel_log_b[(base_b + k) % 512], (7 + k) % B_PAIRS);
            end
        end
        $display("txn wrap10: chal=7 resp=%h lat=%0d", bus_b.response, lat);
        @(negedge clk); bus_b.resp_ready = 1'b1;
        @(posedge clk); #1; bus_b.resp_ready = 1'b0;
        n_checks++; if ({bus_b.resp_valid, bus_b.busy} !== 2'b00) begin n_fail++; $display("FAIL wrap10_ack: got %b want 00", {bus_b.resp_valid, bus_b.busy}); end
    endtask

    // Alternating win/tie, varying race lengths, resp_ready already high
    task automatic test_alternate();
        exp_t e; int lat; bit ok;
        e.lat = 1;
        for (int i = 0; i < 64; i++) begin
            c1_tab[i] = (i % 2 == 0) ? 200 : 50;
            c2_tab[i] = (i % 2 == 0) ? 100 : 50;
            dly_tab[i] = 1 + (i % 4);
            hang_tab[i] = 1'b0;
            if (i < A_BITS) e.lat += A_SETTLE + dly_tab[i] + 2;
        end
        e.resp = 16'h5555; e.tie = 7'd8; e.to = 1'b0;
        sb_q.push_back(e);
        bus_a.resp_ready = 1'b1;
        run_a(4'd5, 6000, lat, ok);
        e = sb_q.pop_front();
        n_checks++; if (!ok || bus_a.response !== e.resp) begin n_fail++; $display("FAIL alt_response: got %h want %h (valid seen %b)", bus_a.response, e.resp, ok); end
        n_checks++; if (bus_a.tie_cnt !== e.tie) begin n_fail++; $display("FAIL alt_tie: got %0d want %0d", bus_a.tie_cnt, e.tie); end
        n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL alt_latency: got %0d want %0d", lat, e.lat); end
        $display("txn alternate: chal=5 resp=%h tie=%0d lat=%0d", bus_a.response, bus_a.tie_cnt, lat);
        @(posedge clk); #1;
        n_checks++; if ({bus_a.resp_valid, bus_a.busy} !== 2'b00) begin n_fail++; $display("FAIL alt_one_cycle_done: got %b want 00", {bus_a.resp_valid, bus_a.busy}); end
        n_checks++; if (bus_a.response !== e.resp) begin n_fail++; $display("FAIL alt_resp_kept: got %h want %h", bus_a.response, e.resp); end
        bus_a.resp_ready = 1'b0;
    endtask

    // Race 3 never finishes: timeout after exactly TIMEOUT_CYCLES
    task automatic test_timeout();
        exp_t e; int lat; bit ok;
        set_tables(200, 100, 2);
        hang_tab[3] = 1'b1;
        e.resp = 16'hFFF7; e.tie = 7'd0; e.to = 1'b1;
        e.lat = (A_BITS - 1) * (A_SETTLE + 2 + 2) + (A_SETTLE + A_TMO + 2) + 1;
        sb_q.push_back(e);
        run_a(4'd0, 6000, lat, ok);
        e = sb_q.pop_front();
        n_checks++; if (!ok || bus_a.response !== e.resp) begin n_fail++; $display("FAIL tmo_response: got %h want %h (valid seen %b)", bus_a.response, e.resp, ok); end
        n_checks++; if (bus_a.timeout_err !== e.to) begin n_fail++; $display("FAIL tmo_flag: got %b want %b", bus_a.timeout_err, e.to); end
        n_checks++; if (bus_a.tie_cnt !== e.tie) begin n_fail++; $display("FAIL tmo_tie: got %0d want %0d", bus_a.tie_cnt, e.tie); end
        n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", lat, e.lat); end
        // cnt_start-high cycles = MEASURE cycles + 1 COMPARE cycle
        n_checks++; if (meas_log_a[(base_a + 3) % 512] != A_TMO + 1) begin n_fail++; $display("FAIL tmo_measure_len: got %0d want %0d", meas_log_a[(base_a + 3) % 512], A_TMO + 1); end
        n_checks++; if (meas_log_a[(base_a + 4) % 512] != 3) begin n_fail++; $display("FAIL tmo_next_race_len: got %0d want 3", meas_log_a[(base_a + 4) % 512]); end
        $display("txn timeout: chal=0 resp=%h to=%b lat=%0d", bus_a.response, bus_a.timeout_err, lat);
        ack_a();
        hang_tab[3] = 1'b0;
    endtask

    // Host stalls in DONE while req pulses; then accepts
    task automatic test_hold();
        exp_t e; int lat; bit ok;
        set_tables(0, 100, 2);
        for (int i = 0; i < 64; i++) c1_tab[i] = i * 10;
        e.resp = 16'hF800; e.tie = 7'd1; e.to = 1'b0; e.lat = A_BITS * (A_SETTLE + 2 + 2) + 1;
        sb_q.push_back(e);
        run_a(4'd2, 6000, lat, ok);
        e = sb_q.pop_front();
        n_checks++; if (!ok || bus_a.response !== e.resp) begin n_fail++; $display("FAIL hold_response: got %h want %h (valid seen %b)", bus_a.response, e.resp, ok); end
        n_checks++; if (bus_a.tie_cnt !== e.tie) begin n_fail++; $display("FAIL hold_tie: got %0d want %0d", bus_a.tie_cnt, e.tie); end
        n_checks++; if (bus_a.timeout_err !== e.to) begin n_fail++; $display("FAIL hold_timeout_cleared: got %b want %b", bus_a.timeout_err, e.to); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus_a.req = (c % 3 == 0);
            bus_a.challenge = 4'(c);
            @(posedge clk); #1;
            n_checks++;
            if ({bus_a.resp_valid, bus_a.busy, bus_a.ro_en, bus_a.response, bus_a.tie_cnt} !== {3'b110, e.resp, e.tie}) begin
                n_fail++; $display("FAIL hold_stable[%0d]: got v=%b busy=%b en=%b resp=%h tie=%0d want v=1 busy=1 en=0 resp=%h tie=%0d",
                    c, bus_a.resp_valid, bus_a.busy, bus_a.ro_en, bus_a.response, bus_a.tie_cnt, e.resp, e.tie);
            end
        end
        @(negedge clk); bus_a.req = 1'b0; bus_a.resp_ready = 1'b1;
        @(posedge clk); #1; bus_a.resp_ready = 1'b0;
        n_checks++; if ({bus_a.resp_valid, bus_a.busy} !== 2'b00) begin n_fail++; $display("FAIL hold_release: got %b want 00", {bus_a.resp_valid, bus_a.busy}); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL hold_no_restart: got busy %b want 0", bus_a.busy); end
        $display("txn hold: chal=2 resp=%h tie=%0d lat=%0d", e.resp, e.tie, lat);
    endtask

    // Reset during MEASURE of race 5, then a fresh full request
    task automatic test_reset_abort();
        exp_t e; int lat; bit ok; bit hit;
        set_tables(200, 100, 2);
        for (int i = 0; i < 5; i++) begin c1_tab[i] = 50; c2_tab[i] = 50; end
        @(negedge clk);
        bus_a.challenge = 4'd3; bus_a.req = 1'b1; base_a = race_a;
        @(posedge clk); #1; bus_a.req = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk); #2;
            if (race_a - base_a >= 6) begin hit = 1'b1; break; end
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL abort_reach_race5: race 5 not started within bound"); end
        n_checks++; if ({bus_a.cnt_start, bus_a.tie_cnt} !== {1'b1, 7'd5}) begin n_fail++; $display("FAIL abort_pre_state: got start=%b tie=%0d want start=1 tie=5", bus_a.cnt_start, bus_a.tie_cnt); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_a.ro_en, bus_a.cnt_start, bus_a.busy, bus_a.resp_valid, bus_a.timeout_err, bus_a.ro_sel, bus_a.tie_cnt, bus_a.response} !== 32'd0) begin
            n_fail++; $display("FAIL abort_async_clear: got en=%b start=%b busy=%b v=%b to=%b sel=%0d tie=%0d resp=%h want all 0",
                bus_a.ro_en, bus_a.cnt_start, bus_a.busy, bus_a.resp_valid, bus_a.timeout_err, bus_a.ro_sel, bus_a.tie_cnt, bus_a.response);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        $display("txn abort: reset during race 5");

        set_tables(200, 100, 2);
        e.resp = 16'hFFFF; e.tie = 7'd0; e.to = 1'b0; e.lat = A_BITS * (A_SETTLE + 2 + 2) + 1;
        sb_q.push_back(e);
        run_a(4'd3, 6000, lat, ok);
        e = sb_q.pop_front();
        n_checks++; if (!ok || bus_a.response !== e.resp) begin n_fail++; $display("FAIL fresh_response: got %h want %h (valid seen %b)", bus_a.response, e.resp, ok); end
        n_checks++; if (bus_a.tie_cnt !== e.tie) begin n_fail++; $display("FAIL fresh_tie: got %0d want %0d", bus_a.tie_cnt, e.tie); end
        n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL fresh_latency: got %0d want %0d", lat, e.lat); end
        n_checks++; if (sel_log_a[base_a % 512] !== 4'd3) begin n_fail++; $display("FAIL fresh_first_sel: got %0d want 3", sel_log_a[base_a % 512]); end
        $display("txn fresh: chal=3 resp=%h tie=%0d lat=%0d", bus_a.response, bus_a.tie_cnt, lat);
        ack_a();
    endtask

    initial begin
        bus_a.req = 1'b0; bus_a.challenge = 4'd0; bus_a.resp_ready = 1'b0;
        bus_b.req = 1'b0; bus_b.challenge = 4'd0; bus_b.resp_ready = 1'b0;
        for (int i = 0; i < 512; i++) begin sel_log_a[i] = 4'd0; meas_log_a[i] = 0; sel_log_b[i] = 4'd0; end
        set_tables(0, 0, 1);
        test_reset();
        test_all_ones();
        test_wrap();
        test_alternate();
        test_timeout();
        test_hold();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
